// File: rtl/systolic_edge_feeder.sv
// rtl/systolic_edge_feeder.sv - skewed, zero-padded operand feeder for the left/top edges of an NxN systolic array
module systolic_edge_feeder #(
  parameter int N            = 4,
  parameter int DW           = 8,
  parameter int DRAIN_CYCLES = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  output logic [N*DW-1:0] a_edge,
  output logic [N*DW-1:0] b_edge,
  output logic            feed_active,
  output logic            busy,
  output logic            done
);

  localparam int CW  = $clog2(2 * N);
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DCW-1:0]     dcnt_q, dcnt_d;
  logic [N*DW-1:0]    a_buf_q [N];
  logic [N*DW-1:0]    a_buf_d [N];
  logic [N*DW-1:0]    b_buf_q [N];
  logic [N*DW-1:0]    b_buf_d [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Operand storage needs no reset: contents are only read after a full load.
  always_ff @(posedge clk) begin
    a_buf_q <= a_buf_d;
    b_buf_q <= b_buf_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
              a_buf_d[k] = in_a;
              b_buf_d[k] = in_b;
            end
          end
          if (cnt_q == CW'(N - 1)) begin
            state_d = S_FEED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FEED: begin
        if (cnt_q == CW'(2 * N - 2)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          dcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DCW'(DRAIN_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Lane i carries the operand whose beat index k satisfies i + k == t; all other lanes idle at zero.
  always_comb begin
    a_edge = '0;
    b_edge = '0;
    if (state_q == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CW'(i + k)) begin
            a_edge[i*DW +: DW] = a_buf_q[k][i*DW +: DW];
            b_edge[i*DW +: DW] = b_buf_q[k][i*DW +: DW];
          end
        end
      end
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign feed_active = (state_q == S_FEED);
  assign busy        = (state_q != S_LOAD);
  assign done        = (state_q == S_DONE);

endmodule

// File: doc/systolic_edge_feeder.md
Name: systolic_edge_feeder

Overview:
- Transmit side of the systolic PE operand interface.
- Buffers one N×N operand set: N beats, each carrying one column of A and one row of B.
- Drives the skewed, zero-padded a_in/b_in streams into the left and top edges of an N×N systolic_pe array.
- After the PE pipeline has drained, signals completion so results can be sampled.

Parameters:
- N, 4, array dimension: number of edge lanes on each side and number of load beats.
- DW, 8, operand width per lane; matches PE a_in/b_in.
- DRAIN_CYCLES, 10, cycles to wait after the last operand before done; legal range ≥1.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  load beat valid
- in_ready  output  1  feeder can accept a load beat
- in_a  input  N*DW  beat k: slice i (bits i*DW +: DW) = A[i][k]
- in_b  input  N*DW  beat k: slice j = B[k][j]
- a_edge  output  N*DW  slice i drives a_in of PE row i, column 0
- b_edge  output  N*DW  slice j drives b_in of PE row 0, column j
- feed_active  output  1  high during FEED state
- busy  output  1  high in FEED, DRAIN and DONE
- done  output  1  one-cycle pulse: results valid at array outputs

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- Reset values: state=LOAD, beat counter=0, in_ready=1, a_edge=0, b_edge=0, feed_active=0, busy=0, done=0. Buffer contents after reset are don't-care.
- Buffer: N entries of A-column and N entries of B-row, each N*DW wide. A beat transfers when in_valid && in_ready on a rising clk edge, and is written to entry k = beat counter.
- LOAD:
  - in_ready=1.
  - Each transfer increments the counter.
  - The transfer with counter==N-1 moves the state to FEED on that same edge and clears the counter.
  - Gaps in in_valid are allowed; the counter holds.
- FEED:
  - in_ready=0, feed_active=1, busy=1.
  - Cycle counter t runs 0..2N-2; FEED lasts exactly 2N-1 cycles.
  - During FEED cycle t: a_edge slice i = A[i][t-i] when 0≤t-i≤N-1, else 0.
  - During FEED cycle t: b_edge slice j = B[t-j][j] when 0≤t-j≤N-1, else 0.
  - Edge values are stable for the whole cycle; they are register outputs or pure functions of registers.
  - After t=2N-2 the state goes to DRAIN.
- DRAIN:
  - in_ready=0, a_edge=b_edge=0, busy=1.
  - Lasts exactly DRAIN_CYCLES cycles, then the state goes to DONE.
- DONE:
  - Lasts one cycle: done=1, busy=1, edges 0, in_ready=0.
  - Next state is LOAD with counter 0.
- Outside FEED, a_edge and b_edge are forced to 0. Zero padding keeps PE accumulations correct.
- in_valid while in_ready=0 is ignored: no buffer write, no counter change. The source must hold the beat.
- Arithmetic: none on data. Operands pass through unmodified, unsigned DW-bit. Counters are sized ceil(log2(2N)) bits minimum and must not wrap within a state.
- Reset asserted mid-operation (any state) immediately returns all outputs to reset values. No done pulse is produced, and any partial load is discarded.
- Latency from the final load handshake edge: FEED starts on the next cycle. done asserts 2N-1+DRAIN_CYCLES cycles after FEED entry.

Test Plan:
1. Reset: hold rst_n=0, drive in_valid=1 → in_ready=1, all edges 0, busy=0, done=0. Release with no valid → state stays LOAD.
2. Continuous load, N=4:
   - Stimulus: A[i][k]=16*i+k+1, B[k][j]=16*k+j+0x81, in_valid high for 4 cycles.
   - in_ready falls the cycle after the 4th beat.
   - FEED t=0: a_edge slice0=0x01, other slices 0.
   - t=3: a_edge slices = {0x04,0x13,0x22,0x31} for i=0..3.
   - t=6: only slice3 nonzero, =0x34.
   - b_edge mirrors this with the B values.
   - feed_active high exactly 7 cycles.
3. Gapped load: in_valid toggling 1,0,0,1,1,0,1 → exactly 4 beats captured in order, edge pattern identical to scenario 2, FEED starts the cycle after the 4th transfer.
4. Backpressure: in_valid held 1 with changing data through FEED/DRAIN/DONE → buffer unchanged, in_ready=0. The first transfer after DONE is beat 0 of the next set.
5. Completion timing: DRAIN_CYCLES=10 → done high for exactly 1 cycle, 17 cycles after FEED entry. busy falls with done; in_ready=1 on the following cycle.
6. Reset mid-FEED at t=3 → edges 0 asynchronously, feed_active=0, no done. The next full load runs normally to done.
